// File: rtl/round_controller_if.sv
// Game-round control bundle: player inputs and start in, door/lives/timer/status out.
interface round_controller_if;
  logic       start;
  logic [1:0] player_1_pos;
  logic [1:0] player_2_pos;
  logic [1:0] correct_door_1;
  logic [1:0] correct_door_2;
  logic [1:0] p1_lives;
  logic [1:0] p2_lives;
  logic [3:0] seconds;
  logic       time_up;
  logic       resume;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output start, player_1_pos, player_2_pos,
    input  correct_door_1, correct_door_2, p1_lives, p2_lives,
           seconds, time_up, resume, game_over, winner
  );

  modport slave (
    input  start, player_1_pos, player_2_pos,
    output correct_door_1, correct_door_2, p1_lives, p2_lives,
           seconds, time_up, resume, game_over, winner
  );
endinterface

// File: rtl/round_controller.sv
// Round sequencer: picks doors from a free-running LFSR, times each round, judges both
// players at time-up, tracks lives and runs the inter-round pause and game-over states.
module round_controller #(
  parameter int         SEC_CYCLES   = 25_000_000,
  parameter int         ROUND_SECS   = 10,
  parameter int         PAUSE_CYCLES = 25_000_000,
  parameter int         START_LIVES  = 3,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  round_controller_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PLAY, JUDGE, PAUSE, OVER} state_e;

  // One counter serves both the seconds prescaler and the pause timer.
  localparam int CNT_MAX = (SEC_CYCLES > PAUSE_CYCLES) ? SEC_CYCLES : PAUSE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SEC_LAST   = CNT_W'(SEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [3:0]       SECS_END   = 4'(ROUND_SECS);
  localparam logic [1:0]       LIVES_INIT = 2'(START_LIVES);

  state_e           state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       door1_q, door1_d;
  logic [1:0]       door2_q, door2_d;
  logic [1:0]       p1_q, p1_d;
  logic [1:0]       p2_q, p2_d;
  logic [3:0]       secs_q, secs_d;
  logic             time_up_q, time_up_d;
  logic             resume_q, resume_d;
  logic             over_q, over_d;
  logic [1:0]       winner_q, winner_d;

  logic [1:0] p1_judged, p2_judged;
  logic       lfsr_fb;

  // Lives saturate at zero so a wrong answer can never wrap a 2-bit count.
  assign p1_judged = (bus.player_1_pos != door1_q && p1_q != 2'd0) ? p1_q - 2'd1 : p1_q;
  assign p2_judged = (bus.player_2_pos != door2_q && p2_q != 2'd0) ? p2_q - 2'd1 : p2_q;

  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
    state_d   = state_q;
    lfsr_d    = {lfsr_q[6:0], lfsr_fb};
    cnt_d     = cnt_q;
    door1_d   = door1_q;
    door2_d   = door2_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    secs_d    = secs_q;
    time_up_d = time_up_q;
    resume_d  = 1'b0;
    over_d    = over_q;
    winner_d  = winner_q;

    unique case (state_q)
      IDLE, OVER: begin
        if (bus.start) begin
          state_d   = PLAY;
          cnt_d     = '0;
          door1_d   = lfsr_q[1:0];
          door2_d   = lfsr_q[3:2];
          p1_d      = LIVES_INIT;
          p2_d      = LIVES_INIT;
          secs_d    = 4'd0;
          time_up_d = 1'b0;
          over_d    = 1'b0;
          winner_d  = 2'b00;
        end
      end

      PLAY: begin
        if (cnt_q == SEC_LAST) begin
          cnt_d  = '0;
          secs_d = secs_q + 4'd1;
          if (secs_q + 4'd1 == SECS_END) begin
            state_d   = JUDGE;
            time_up_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      JUDGE: begin
        p1_d  = p1_judged;
        p2_d  = p2_judged;
        cnt_d = '0;
        if (p1_judged == 2'd0 || p2_judged == 2'd0) begin
          state_d  = OVER;
          over_d   = 1'b1;
          // Bit 1 flags player 1 out, bit 0 player 2 out, so the survivor is the winner.
          winner_d = {p1_judged == 2'd0, p2_judged == 2'd0};
        end else begin
          state_d = PAUSE;
        end
      end

      PAUSE: begin
        if (cnt_q == PAUSE_LAST) begin
          state_d   = PLAY;
          cnt_d     = '0;
          resume_d  = 1'b1;
          time_up_d = 1'b0;
          secs_d    = 4'd0;
          door1_d   = lfsr_q[1:0];
          door2_d   = lfsr_q[3:2];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_SEED;
      cnt_q     <= '0;
      door1_q   <= 2'b00;
      door2_q   <= 2'b00;
      p1_q      <= LIVES_INIT;
      p2_q      <= LIVES_INIT;
      secs_q    <= 4'd0;
      time_up_q <= 1'b0;
      resume_q  <= 1'b0;
      over_q    <= 1'b0;
      winner_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      door1_q   <= door1_d;
      door2_q   <= door2_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      secs_q    <= secs_d;
      time_up_q <= time_up_d;
      resume_q  <= resume_d;
      over_q    <= over_d;
      winner_q  <= winner_d;
    end
  end

  assign bus.correct_door_1 = door1_q;
  assign bus.correct_door_2 = door2_q;
  assign bus.p1_lives       = p1_q;
  assign bus.p2_lives       = p2_q;
  assign bus.seconds        = secs_q;
  assign bus.time_up        = time_up_q;
  assign bus.resume         = resume_q;
  assign bus.game_over      = over_q;
  assign bus.winner         = winner_q;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller: a timeline model derives every output from the
// cycles elapsed in the round, checked each falling edge, plus hand-computed literals.
module tb_round_controller;
  localparam int S     = 4;
  localparam int R     = 3;
  localparam int P     = 5;
  localparam int LIVES = 3;
  localparam logic [7:0] SEED = 8'hA5;
  localparam int RS    = R * S;

  logic clk = 1'b0;
  logic rst_n;
  round_controller_if bus();

  round_controller #(
    .SEC_CYCLES(S), .ROUND_SECS(R), .PAUSE_CYCLES(P),
    .START_LIVES(LIVES), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 = waiting for start, 1 = in a round (t = cycles since round began), 2 = game over.
  int         m_mode, t, m_l1, m_l2;
  logic [7:0] m_lfsr, prev;
  logic [1:0] m_door1, m_door2, m_win;
  bit         m_resume;

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0; t = 0; m_lfsr = SEED; m_door1 = 0; m_door2 = 0;
        m_l1 = LIVES; m_l2 = LIVES; m_win = 0; m_resume = 0;
      end else begin
        prev     = m_lfsr;
        m_lfsr   = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        m_resume = 0;
        if (m_mode != 1) begin
          if (bus.start) begin
            m_mode = 1; t = 0; m_door1 = prev[1:0]; m_door2 = prev[3:2];
            m_l1 = LIVES; m_l2 = LIVES; m_win = 0;
          end
        end else if (t == RS) begin
          if (bus.player_1_pos != m_door1 && m_l1 > 0) m_l1--;
          if (bus.player_2_pos != m_door2 && m_l2 > 0) m_l2--;
          if (m_l1 == 0 || m_l2 == 0) begin
            m_mode = 2;
            m_win  = {m_l1 == 0, m_l2 == 0};
          end else begin
            t++;
          end
        end else if (t == RS + P) begin
          t = 0; m_resume = 1; m_door1 = prev[1:0]; m_door2 = prev[3:2];
        end else begin
          t++;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int e_secs;
    bit e_tu;
    if (chk_en) begin
      e_secs = (m_mode == 1) ? ((t < RS) ? t / S : R) : ((m_mode == 2) ? R : 0);
      e_tu   = (m_mode == 2) || (m_mode == 1 && t >= RS);
      check("seconds",   bus.seconds,        e_secs);
      check("time_up",   bus.time_up,        e_tu);
      check("resume",    bus.resume,         m_resume);
      check("game_over", bus.game_over,      m_mode == 2);
      check("winner",    bus.winner,         m_win);
      check("p1_lives",  bus.p1_lives,       m_l1);
      check("p2_lives",  bus.p2_lives,       m_l2);
      check("door1",     bus.correct_door_1, m_door1);
      check("door2",     bus.correct_door_2, m_door2);
    end
  end

  task automatic wait_for(input bit want_resume, input int limit, output int n);
    n = 0;
    while (((want_resume ? bus.resume : bus.time_up) !== 1'b1) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if ((want_resume ? bus.resume : bus.time_up) !== 1'b1)
      check(want_resume ? "resume_timeout" : "time_up_timeout", 0, 1);
  endtask

  // Called on the first falling edge of a round; returns on the falling edge after judging.
  task automatic run_round(input bit w1, input bit w2);
    int n;
    bus.player_1_pos = m_door1 ^ {1'b0, w1};
    bus.player_2_pos = m_door2 ^ {1'b0, w2};
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    wait_for(1'b0, 40, n);
    @(negedge clk);
  endtask

  task automatic new_game();
    bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    check("ng_p1_lives",  bus.p1_lives,  3);
    check("ng_p2_lives",  bus.p2_lives,  3);
    check("ng_game_over", bus.game_over, 0);
    check("ng_seconds",   bus.seconds,   0);
    check("ng_winner",    bus.winner,    0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.player_1_pos = 2'b00;
    bus.player_2_pos = 2'b00;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_door1",     bus.correct_door_1, 0);
    check("rst_door2",     bus.correct_door_2, 0);
    check("rst_p1_lives",  bus.p1_lives,       3);
    check("rst_p2_lives",  bus.p2_lives,       3);
    check("rst_time_up",   bus.time_up,        0);
    check("rst_game_over", bus.game_over,      0);

    // First edge after release sees the seed 8'hA5: both doors = 2'b01.
    rst_n = 1'b1;
    bus.start = 1'b1;
    bus.player_1_pos = 2'b01;
    bus.player_2_pos = 2'b01;
    @(negedge clk) bus.start = 1'b0;
    check("r1_door1", bus.correct_door_1, 1);
    check("r1_door2", bus.correct_door_2, 1);
    wait_for(1'b0, 40, n);
    check("time_up_latency", n, 12);
    wait_for(1'b1, 40, n);
    check("time_up_len", n, 6);
    check("r1_seconds",  bus.seconds,  0);
    check("r1_p1_lives", bus.p1_lives, 3);
    check("r1_p2_lives", bus.p2_lives, 3);

    // Player 1 wrong, player 2 right; start pulses inside the round and the pause.
    run_round(1'b1, 1'b0);
    check("r2_p1_lives",  bus.p1_lives,  2);
    check("r2_p2_lives",  bus.p2_lives,  3);
    check("r2_game_over", bus.game_over, 0);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    wait_for(1'b1, 20, n);

    run_round(1'b1, 1'b0);
    check("r3_p1_lives", bus.p1_lives, 1);
    wait_for(1'b1, 20, n);

    run_round(1'b1, 1'b0);
    check("r4_p1_lives",  bus.p1_lives,  0);
    check("r4_p2_lives",  bus.p2_lives,  3);
    check("r4_game_over", bus.game_over, 1);
    check("r4_winner",    bus.winner,    2);
    repeat (8) @(negedge clk);
    check("over_seconds", bus.seconds, 3);
    check("over_time_up", bus.time_up, 1);

    new_game();
    run_round(1'b1, 1'b1);
    wait_for(1'b1, 20, n);
    run_round(1'b1, 1'b1);
    wait_for(1'b1, 20, n);
    run_round(1'b1, 1'b1);
    check("draw_p1_lives", bus.p1_lives, 0);
    check("draw_p2_lives", bus.p2_lives, 0);
    check("draw_winner",   bus.winner,   3);
    repeat (10) @(negedge clk);
    check("draw_hold_p1", bus.p1_lives, 0);
    check("draw_hold_p2", bus.p2_lives, 0);

    // Reset lands on pause cycle 3 of a clean round.
    new_game();
    run_round(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("prst_time_up",  bus.time_up,  0);
    check("prst_resume",   bus.resume,   0);
    check("prst_seconds",  bus.seconds,  0);
    check("prst_p1_lives", bus.p1_lives, 3);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_resume",  bus.resume,  0);
    check("idle_time_up", bus.time_up, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/round_controller.md
Name: round_controller

Overview:
- Game-round sequencer that drives `screen_drawer`, the 7-segment timer path and the status LEDs.
- Picks each round's correct doors with a free-running LFSR and counts the round seconds.
- At time-up, judges both player positions, decrements lives and runs the inter-round pause.
- Flags game over and the winner, replacing the hardwired door, lives, time_up and resume signals in `main`.

Parameters:
- SEC_CYCLES, 25_000_000, clk cycles per game second (VGA_CLK = 25 MHz).
- ROUND_SECS, 10, seconds per round; range 1..15.
- PAUSE_CYCLES, 25_000_000, length of the post-judge pause in clk cycles; must be ≥1.
- START_LIVES, 3, lives per player at game start; range 1..3.
- LFSR_SEED, 8'hA5, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  pixel clock (VGA_CLK).
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level/pulse; sampled only in IDLE or OVER.
- player_1_pos  in  2  door chosen by player 1.
- player_2_pos  in  2  door chosen by player 2.
- correct_door_1  out  2  correct door for player 1 this round.
- correct_door_2  out  2  correct door for player 2 this round.
- p1_lives  out  2  remaining lives, player 1.
- p2_lives  out  2  remaining lives, player 2.
- seconds  out  4  elapsed whole seconds in the current round (feeds BinToBCD).
- time_up  out  1  high from judge until resume, and in OVER.
- resume  out  1  single-cycle pulse marking the start of the next round.
- game_over  out  1  high in OVER.
- winner  out  2  00 none, 01 player 1, 10 player 2, 11 draw.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 except p1_lives = p2_lives = START_LIVES; LFSR = LFSR_SEED; cycle counters = 0.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every clk in every state, never reaches 0.
- States: IDLE, PLAY, JUDGE, PAUSE, OVER. All outputs are registered.
- IDLE or OVER with start=1:
  - next state PLAY;
  - correct_door_1 <= lfsr[1:0], correct_door_2 <= lfsr[3:2];
  - lives <= START_LIVES; seconds <= 0; game_over <= 0; winner <= 0; time_up <= 0.
- PLAY:
  - Cycle counter runs 0..SEC_CYCLES-1; on terminal count it wraps to 0 and seconds increments.
  - The increment that makes seconds == ROUND_SECS also moves the state to JUDGE and sets time_up = 1 on the same edge.
  - Round length is exactly ROUND_SECS*SEC_CYCLES cycles from entering PLAY.
- JUDGE (exactly 1 cycle):
  - Sample player_1_pos and player_2_pos.
  - Mismatch with the corresponding correct door → that player's lives decrement, saturating at 0.
  - Both players are judged on the same edge.
  - If either new lives value is 0 → OVER, else → PAUSE.
  - seconds holds ROUND_SECS.
- PAUSE:
  - Counts PAUSE_CYCLES cycles; time_up stays 1.
  - On the last pause cycle's edge: resume = 1 for one cycle, time_up <= 0, seconds <= 0, new doors loaded from the LFSR (same bit slices), state → PLAY.
- OVER:
  - game_over = 1, time_up = 1, seconds frozen.
  - winner: 01 if only p2 is at 0; 10 if only p1 is at 0; 11 if both are at 0.
  - Doors are held.
- start is ignored in PLAY, JUDGE and PAUSE.
- Player position changes outside JUDGE have no effect.
- Reset asserted in any state returns immediately to IDLE with reset values; an in-progress pause produces no resume pulse.
- Width rules: lives are 2-bit unsigned and never wrap below 0; seconds never exceeds ROUND_SECS.

Test Plan:
Params for all scenarios: SEC_CYCLES=4, ROUND_SECS=3, PAUSE_CYCLES=5, START_LIVES=3.
1. Assert reset low mid-operation → state IDLE, lives=3/3, time_up=0, resume=0, game_over=0, winner=00, seconds=0, doors=00.
2. start pulse, positions = doors → seconds steps 1,2,3 every 4 cycles; time_up rises 12 cycles after entering PLAY; lives stay 3/3; time_up high for 6 cycles; 1-cycle resume pulse; seconds=0; new doors equal the LFSR slices at that edge.
3. Round with player_1_pos ≠ correct_door_1 and player 2 correct → p1_lives 3→2, p2_lives 3, state PAUSE (not OVER).
4. p1 at 1 life loses, p2 correct → p1_lives=0, game_over=1, winner=10, time_up held, no resume pulse; then start → lives 3/3, game_over=0, seconds=0, PLAY.
5. Both players at 1 life and both wrong → both lives 0, winner=11; a further wrong judge never occurs and lives stay 0 with no wrap.
6. start pulsed during PLAY and during PAUSE → no effect on seconds, lives or doors; reset asserted on pause cycle 3 → IDLE next, time_up=0, no resume pulse.
